event_array_arbiter: RTL and testbench

EVENT_ARRAY_ARBITER -- requirements
Module: event_array_arbiter

---
 rtl/event_array_arbiter.sv | 120 ++++++++++++
 tb/tb_event_array_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/event_array_arbiter.sv
// event_array_arbiter
//   Turns rising edges on an array of event levels into a stream of reports.
//   Each channel holds at most one pending event; a pending channel is
//   reported round-robin through a single valid/ready output register.
//   A rise on a channel that is already pending (and not being granted that
//   cycle) is lost and counted in a saturating drop counter.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   ev         per-channel event levels (0->1 transition = one event)
//   out_valid  report available
//   out_ready  consumer accepts the report when high together with out_valid
//   out_chan   channel index of the report
//   out_num    NUM_BASE + out_chan*NUM_STRIDE, truncated to NUMW bits
//   pending    per-channel pending-event flags
//   drop_cnt   saturating count of lost events
module event_array_arbiter #(
    parameter int WID        = 5,
    parameter int NUM_BASE   = 0,
    parameter int NUM_STRIDE = 1,
    parameter int NUMW       = 16,
    parameter int CNTW       = 8,
    localparam int CW        = (WID > 1) ? $clog2(WID) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WID-1:0]  ev,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_chan,
    output logic [NUMW-1:0] out_num,
    output logic [WID-1:0]  pending,
    output logic [CNTW-1:0] drop_cnt
);

    logic [WID-1:0]     ev_q;
    logic [WID-1:0]     rise;
    logic [WID-1:0]     grant_mask;
    logic [WID-1:0]     drop_mask;
    logic [CW-1:0]      rr_ptr;
    logic [CW-1:0]      sel;
    logic [NUMW-1:0]    num_sel;
    logic               load_en;
    logic               any_pend;
    logic               found;
    int unsigned        ndrop;
    logic [CNTW+31:0]   cnt_sum;

    assign rise     = ev & ~ev_q;
    assign any_pend = |pending;
    assign load_en  = ~out_valid | out_ready;

    // Round-robin search starting one past the last grant, wrapping at WID.
    always_comb begin
        int unsigned idx;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= WID; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= WID) begin
                idx = idx - WID;
            end
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = CW'(idx);
            end
        end
    end

    always_comb begin
        num_sel = NUMW'(NUM_BASE + int'(sel) * NUM_STRIDE);
    end

    // A channel being granted this cycle may re-arm without counting a drop.
    always_comb begin
        grant_mask = '0;
        if (load_en && any_pend) begin
            grant_mask[sel] = 1'b1;
        end
        drop_mask = rise & pending & ~grant_mask;
        ndrop     = 0;
        for (int unsigned i = 0; i < WID; i++) begin
            ndrop = ndrop + 32'(drop_mask[i]);
        end
        cnt_sum = {32'b0, drop_cnt} + (CNTW + 32)'(ndrop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_q      <= '0;
            pending   <= '0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_num   <= NUMW'(NUM_BASE);
            drop_cnt  <= '0;
            rr_ptr    <= CW'(WID - 1);
        end else begin
            ev_q    <= ev;
            pending <= (pending & ~grant_mask) | rise;
            if (cnt_sum > {32'b0, {CNTW{1'b1}}}) begin
                drop_cnt <= '1;
            end else begin
                drop_cnt <= cnt_sum[CNTW-1:0];
            end
            if (load_en) begin
                if (any_pend) begin
                    out_valid <= 1'b1;
                    out_chan  <= sel;
                    out_num   <= num_sel;
                    rr_ptr    <= sel;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_event_array_arbiter.sv
module tb_event_array_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  ev;
    logic        out_ready;
    logic        out_valid;
    logic [2:0]  out_chan;
    logic [15:0] out_num;
    logic [4:0]  pending;
    logic [7:0]  drop_cnt;

    logic [2:0]  ev3;
    logic        rdy3;
    logic        out_valid3;
    logic [1:0]  out_chan3;
    logic [15:0] out_num3;
    logic [2:0]  pending3;
    logic [1:0]  drop_cnt3;

    event_array_arbiter dut (
        .clk(clk), .rst(rst), .ev(ev),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan), .out_num(out_num),
        .pending(pending), .drop_cnt(drop_cnt)
    );

    event_array_arbiter #(.WID(3), .NUM_BASE(100), .NUM_STRIDE(10), .NUMW(16), .CNTW(2)) dut3 (
        .clk(clk), .rst(rst), .ev(ev3),
        .out_valid(out_valid3), .out_ready(rdy3),
        .out_chan(out_chan3), .out_num(out_num3),
        .pending(pending3), .drop_cnt(drop_cnt3)
    );

    int total = 0;
    int bad   = 0;
    int sb_a[$];
    int sb_b[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepted reports are compared against the scoreboards.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_a.size() == 0) begin
                check("a_unexpected_report", 32'(out_chan), 32'hFFFF);
            end else begin
                int e;
                e = sb_a.pop_front();
                check("a_chan", 32'(out_chan), 32'(e));
                check("a_num", 32'(out_num), 32'(e));
            end
        end
        if (!rst && out_valid3 && rdy3) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_report", 32'(out_num3), 32'hFFFF);
            end else begin
                int e;
                e = sb_b.pop_front();
                check("b_num", 32'(out_num3), 32'(e));
            end
        end
    end

    initial begin
        rst = 1'b1; ev = '0; out_ready = 1'b1; ev3 = '0; rdy3 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_chan", 32'(out_chan), 0);
        check("rst_num", 32'(out_num), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_b_num", 32'(out_num3), 100);

        // Walking one: report n-2 visible after edge n.
        for (int i = 0; i < 5; i++) sb_a.push_back(i);
        for (int n = 1; n <= 7; n++) begin
            ev = (n <= 5) ? 5'(1 << (n - 1)) : 5'd0;
            tick();
            if (n >= 2 && n <= 6) begin
                check("walk_valid", 32'(out_valid), 1);
                check("walk_chan", 32'(out_chan), 32'(n - 2));
            end
        end
        check("walk_idle", 32'(out_valid), 0);
        check("walk_drop", 32'(drop_cnt), 0);

        // Simultaneous rise on all channels.
        for (int i = 0; i < 5; i++) sb_a.push_back(i);
        ev = 5'h1F;
        tick();
        ev = '0;
        check("sim_pending", 32'(pending), 32'h1F);
        for (int n = 0; n < 5; n++) begin
            tick();
            check("sim_chan", 32'(out_chan), 32'(n));
        end
        tick();
        check("sim_idle", 32'(out_valid), 0);

        // Backpressure on channel 2.
        out_ready = 1'b0;
        ev = 5'd4; tick(); ev = '0; tick();
        check("bp_load_valid", 32'(out_valid), 1);
        check("bp_load_chan", 32'(out_chan), 2);
        ev = 5'd4; tick(); ev = '0; tick();
        check("bp_pending", 32'(pending), 4);
        check("bp_drop0", 32'(drop_cnt), 0);
        ev = 5'd4; tick(); ev = '0; tick();
        check("bp_drop1", 32'(drop_cnt), 1);
        check("bp_hold_chan", 32'(out_chan), 2);
        check("bp_hold_valid", 32'(out_valid), 1);
        sb_a.push_back(2); sb_a.push_back(2);
        out_ready = 1'b1;
        tick(); tick();
        check("bp_idle", 32'(out_valid), 0);

        // Fairness after a channel-3 grant; rise on held channel 3 is not a drop.
        out_ready = 1'b0;
        ev = 5'd8; tick(); ev = '0; tick();
        check("fair_chan3", 32'(out_chan), 3);
        ev = 5'h1A; tick(); ev = '0; tick();
        check("fair_pending", 32'(pending), 32'h1A);
        check("fair_drop", 32'(drop_cnt), 1);
        sb_a.push_back(3); sb_a.push_back(4); sb_a.push_back(1); sb_a.push_back(3);
        out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        check("fair_idle", 32'(out_valid), 0);

        // Reset in the middle of activity.
        out_ready = 1'b0;
        ev = 5'h1F; tick(); ev = '0; tick();
        ev = 5'h1F; tick();
        check("mid_valid", 32'(out_valid), 1);
        check("mid_drop", 32'(drop_cnt), 5);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; ev = '0;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_chan", 32'(out_chan), 0);
        check("mid_rst_num", 32'(out_num), 0);
        check("mid_rst_pending", 32'(pending), 0);
        check("mid_rst_drop", 32'(drop_cnt), 0);
        tick(); tick(); tick();
        check("mid_quiet_valid", 32'(out_valid), 0);
        check("mid_quiet_pending", 32'(pending), 0);

        // Level high through reset release counts as a rise.
        out_ready = 1'b0;
        rst = 1'b1; ev = 5'd1; tick();
        rst = 1'b0; tick();
        check("rel_pending", 32'(pending), 1);
        sb_a.push_back(0);
        out_ready = 1'b1;
        tick(); tick();
        ev = '0;
        check("rel_idle", 32'(out_valid), 0);

        // Parameterised instance: numbering and drop saturation.
        sb_b.push_back(100); sb_b.push_back(110); sb_b.push_back(120);
        rdy3 = 1'b1;
        ev3 = 3'h7; tick(); ev3 = '0;
        tick(); tick(); tick(); tick();
        check("b_idle", 32'(out_valid3), 0);
        check("b_drop0", 32'(drop_cnt3), 0);
        rdy3 = 1'b0;
        ev3 = 3'h7; tick(); ev3 = '0; tick();
        ev3 = 3'h7; tick(); ev3 = '0; tick();
        check("b_drop2", 32'(drop_cnt3), 2);
        ev3 = 3'h7; tick(); ev3 = '0; tick();
        check("b_drop_sat", 32'(drop_cnt3), 3);
        check("b_pending", 32'(pending3), 7);

        tick();
        check("sb_a_drained", 32'(sb_a.size()), 0);
        check("sb_b_drained", 32'(sb_b.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
